// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller and its mul/div sequencer.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

endpackage

// File: rtl/md_sequencer.sv
// Fixed-latency mul/div sequencer: stalls for MD_LATENCY-1 cycles, then pulses MdDone.
// Stall and done are decoded from state so the first stall cycle coincides with MdStartE.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MdStartE,
  output logic mdStall,
  output logic MdBusy,
  output logic MdDone
);

  localparam bit MULTI = (MD_LATENCY > 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = MULTI ? CNT_WIDTH'(MD_LATENCY - 2) : '0;

  md_state_t             state;
  logic [CNT_WIDTH-1:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (MdStartE && MULTI) begin
            state <= MD_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) state <= MD_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even if MdStartE is asserted.
  always_comb begin
    mdStall = 1'b0;
    MdDone  = 1'b0;
    if (rst_n) begin
      if (state == MD_IDLE) begin
        mdStall = MdStartE && MULTI;
        MdDone  = MdStartE && !MULTI;
      end else begin
        mdStall = (cnt != '0);
        MdDone  = (cnt == '0);
      end
    end
    MdBusy = rst_n && ((state == MD_BUSY) || mdStall);
  end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding, load-use, branch-flush and mul/div stall control for the 5-stage pipe.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and flush counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int MD_LATENCY             = 4,
  parameter int CNT_WIDTH              = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic                              MdStartE,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              StallE,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic                              FlushM,
  output logic                              MdBusy,
  output logic                              MdDone
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                       StallCycles,
  output logic [31:0]                       FlushCount
`endif
);

  logic mdStall;
  logic lwStall;
  logic pcFlush;

  md_sequencer #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .MdStartE (MdStartE),
    .mdStall  (mdStall),
    .MdBusy   (MdBusy),
    .MdDone   (MdDone)
  );

  function automatic logic [1:0] fwd_sel(input logic [REG_FILE_ADDRESS_WIDTH-1:0] rs);
    if (RegWriteM && RdM != '0 && RdM == rs)      return FWD_MEM;
    else if (RegWriteW && RdW != '0 && RdW == rs) return FWD_WB;
    else                                          return FWD_REG;
  endfunction

  // A mul/div in execute owns the pipe: a coincident PCSrcE is an illegal encoding and is masked.
  always_comb begin
    lwStall   = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);
    pcFlush   = PCSrcE && !MdStartE && !mdStall;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    if (rst_n) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      StallF    = lwStall || mdStall;
      StallD    = lwStall || mdStall;
      StallE    = mdStall;
      FlushD    = pcFlush;
      FlushE    = (lwStall || pcFlush) && !mdStall;
      FlushM    = mdStall;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && StallCycles != '1)                       StallCycles <= StallCycles + 1'b1;
      if ((FlushD || FlushE || FlushM) && FlushCount != '1) FlushCount  <= FlushCount + 1'b1;
    end
  end
`endif

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Hazard and sequencing controller for the 5-stage pipeline; drives the execute stage's ForwardAE/ForwardBE selects and all stage stall/flush controls.
- Resolves RAW forwarding, load-use stalls and taken-branch/jump flushes.
- Sequences a fixed-latency multi-cycle mul/div operation resident in execute, holding the front of the pipe and bubbling memory until the result is ready.

Parameters:
- REG_FILE_ADDRESS_WIDTH, 5, register index width
- MD_LATENCY, 4, total cycles a mul/div instruction occupies execute (>=1; 1 = no stall)
- CNT_WIDTH, 3, width of the mul/div cycle counter; must hold MD_LATENCY-2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  REG_FILE_ADDRESS_WIDTH  source registers in decode
- Rs1E, Rs2E, RdE  in  REG_FILE_ADDRESS_WIDTH  source and destination registers in execute
- RdM, RdW  in  REG_FILE_ADDRESS_WIDTH  destination registers in memory and writeback
- RegWriteM, RegWriteW  in  1  write-enables in memory and writeback
- ResultSrcE  in  2  execute result select; 2'b01 = load
- PCSrcE  in  1  taken branch or jump resolved in execute
- MdStartE  in  1  execute instruction is mul/div
- ForwardAE, ForwardBE  out  2  operand forward selects
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  bubble the IF/ID, ID/EX and EX/MEM registers
- MdBusy  out  1  mul/div sequencer not idle
- MdDone  out  1  one-cycle pulse: mul/div result valid this cycle

Behaviour:
- Forwarding (combinational), same rule for B using Rs2E:
  - ForwardAE=2'b10 if RegWriteM && RdM!=0 && RdM==Rs1E
  - else 2'b01 if RegWriteW && RdW!=0 && RdW==Rs1E
  - else 2'b00
  - Memory stage has priority over writeback. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - Gives StallF=StallD=1, FlushE=1.
  - No stall when RdE==0.
- Control hazard: PCSrcE gives FlushD=1, FlushE=1.
  - If PCSrcE and lwStall occur together, both are applied: FlushD, FlushE, StallF and StallD all 1. The flush supersedes the decode hold.
- Mul/div FSM, states IDLE and BUSY, counter cnt:
  - IDLE, MdStartE=1, MD_LATENCY>1: mdStall=1; next state BUSY; cnt<=MD_LATENCY-2.
  - IDLE, MD_LATENCY==1: MdDone=1 the same cycle; no stall.
  - BUSY, cnt!=0: mdStall=1; cnt<=cnt-1.
  - BUSY, cnt==0: mdStall=0; MdDone=1; next state IDLE.
  - Total stall cycles = MD_LATENCY-1.
- While mdStall=1:
  - StallF=StallD=StallE=1 and FlushM=1.
  - FlushE=0: load-use flush is suppressed so the mul/div op is not killed.
  - MdStartE is ignored while in BUSY.
- MdBusy=1 whenever state==BUSY or mdStall=1.
- Priority when MdStartE=1 and PCSrcE=1 together (illegal encoding): mul/div sequencing wins and PCSrcE flushes are masked.
- Back-to-back mul/div:
  - The cycle after MdDone returns to IDLE.
  - A new MdStartE is then accepted immediately; there is no idle gap.
- Reset:
  - While rst_n=0, all outputs are 0.
  - Asynchronous return to IDLE with cnt=0, including mid-BUSY. The abandoned op produces no MdDone.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs StallCycles[31:0] and FlushCount[31:0].
  - StallCycles increments on every cycle with StallF=1.
  - FlushCount increments on every cycle with FlushD|FlushE|FlushM.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - forward encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - RESULT_SRC_LOAD=2'b01
  - md_state_t enum {MD_IDLE, MD_BUSY}
- One sub-module, md_sequencer: the FSM plus counter, outputting mdStall, MdBusy and MdDone.
- hazard_controller holds forwarding, load-use and flush logic, plus the perf counters.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10. Then RegWriteM=0 -> 2'b01. Then RdM=RdW=0, Rs1E=0 -> 2'b00.
- ResultSrcE=2'b01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. Repeat with RdE=0 -> no stall.
- PCSrcE=1 together with a load-use match -> FlushD=FlushE=1 and StallF=StallD=1 in the same cycle.
- MD_LATENCY=4, MdStartE held high -> StallF/StallD/StallE/FlushM high for 3 cycles, MdDone on cycle 4, MdBusy high cycles 1-4.
  - Repeat with a simultaneous load-use match: FlushE stays 0.
- Two mul/div ops back-to-back -> second stall window starts the cycle after the first MdDone; 6 stall cycles total.
- rst_n low during cycle 2 of BUSY -> all outputs 0 at once, no MdDone. A new MdStartE after release gives a full 3-cycle stall.
  - With HAZARD_PERF_EN defined, counters read 0 after reset.
